// File: rtl/arith_pkg.sv
// Shared operation-select encoding for the arithmetic unit.
package arith_pkg;

  typedef enum logic [1:0] {
    SEL_ADD   = 2'b00,
    SEL_ADDNB = 2'b01,
    SEL_ZERO  = 2'b10,
    SEL_ONES  = 2'b11
  } arith_sel_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the link of the ripple carry chain.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/arithmetic_circuit.sv
// Registered D = A + Y + Cin with selectable B-side operand and a valid flag.
// Optional signed-overflow output v_o when ARITH_OVERFLOW_EN is defined.
module arithmetic_circuit
  import arith_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic [1:0]       sel_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] d_o,
`ifdef ARITH_OVERFLOW_EN
  output logic             v_o,
`endif
  output logic             cout_o
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;

  logic             r_valid;
  logic [WIDTH-1:0] r_d;
  logic             r_cout;

  always_comb begin
    w_y = b_i;
    case (arith_sel_t'(sel_i))
      SEL_ADD:   w_y = b_i;
      SEL_ADDNB: w_y = ~b_i;
      SEL_ZERO:  w_y = '0;
      SEL_ONES:  w_y = '1;
      default:   w_y = b_i;
    endcase
  end

  assign w_carry[0] = cin_i;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    full_adder u_fa (
      .i_a    (a_i[gi]),
      .i_b    (w_y[gi]),
      .i_cin  (w_carry[gi]),
      .o_s    (w_sum[gi]),
      .o_cout (w_carry[gi+1])
    );
  end

  // Result holds when no new operands arrive; only the valid flag drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_d     <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_d    <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end
  end

`ifdef ARITH_OVERFLOW_EN
  logic r_v;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v <= 1'b0;
    end else if (valid_i) begin
      r_v <= w_carry[WIDTH-1] ^ w_carry[WIDTH];
    end
  end

  assign v_o = r_v;
`endif

  assign valid_o = r_valid;
  assign d_o     = r_d;
  assign cout_o  = r_cout;

endmodule

// File: tb/tb_arithmetic_circuit.sv
// Self-checking bench driving a 1-bit and an 8-bit instance from shared stimulus.
module tb_arithmetic_circuit;

  logic       clk;
  logic       rstN;
  logic       validIn;
  logic [7:0] aIn;
  logic [7:0] bIn;
  logic       cinIn;
  logic [1:0] selIn;

  logic       valid1, cout1;
  logic [0:0] d1;
  logic       valid8, cout8;
  logic [7:0] d8;
`ifdef ARITH_OVERFLOW_EN
  logic       v1, v8;
`endif

  int nAsserts = 0;
  int nFails   = 0;

  // Expected state of each instance, maintained by the reference model
  logic [7:0] expD8, expD1;
  logic       expC8, expC1, expV8, expV1, expValid;

  arithmetic_circuit #(.WIDTH(1)) u_dut1 (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .valid_i (validIn),
    .a_i     (aIn[0:0]),
    .b_i     (bIn[0:0]),
    .cin_i   (cinIn),
    .sel_i   (selIn),
    .valid_o (valid1),
    .d_o     (d1),
`ifdef ARITH_OVERFLOW_EN
    .v_o     (v1),
`endif
    .cout_o  (cout1)
  );

  arithmetic_circuit #(.WIDTH(8)) u_dut8 (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .valid_i (validIn),
    .a_i     (aIn),
    .b_i     (bIn),
    .cin_i   (cinIn),
    .sel_i   (selIn),
    .valid_o (valid8),
    .d_o     (d8),
`ifdef ARITH_OVERFLOW_EN
    .v_o     (v8),
`endif
    .cout_o  (cout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain-arithmetic reference: w-bit unsigned sum plus signed overflow by sign rule
  task automatic refModel(input int w, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] s, input logic c,
                          output logic [7:0] d, output logic co, output logic ov);
    int mask, av, yv, sum;
    mask = (1 << w) - 1;
    av   = int'(a) & mask;
    case (s)
      2'd0:    yv = int'(b) & mask;
      2'd1:    yv = (~int'(b)) & mask;
      2'd2:    yv = 0;
      default: yv = mask;
    endcase
    sum = av + yv + int'(c);
    d   = 8'(sum & mask);
    co  = ((sum >> w) & 1) != 0;
    ov  = (((av >> (w-1)) & 1) == ((yv >> (w-1)) & 1)) &&
          (((sum >> (w-1)) & 1) != ((av >> (w-1)) & 1));
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    nAsserts++;
    assert (obs === expv)
    else begin
      nFails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] s, input logic c);
    logic [7:0] d;
    logic       co, ov;
    @(negedge clk);
    validIn = v;
    aIn     = a;
    bIn     = b;
    selIn   = s;
    cinIn   = c;
    if (v) begin
      refModel(8, a, b, s, c, d, co, ov);
      expD8 = d; expC8 = co; expV8 = ov;
      refModel(1, a, b, s, c, d, co, ov);
      expD1 = d; expC1 = co; expV1 = ov;
    end
    expValid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".valid1"}, 9'(valid1), 9'(expValid));
    chk({tag, ".d1"},     9'(d1),     9'(expD1));
    chk({tag, ".cout1"},  9'(cout1),  9'(expC1));
    chk({tag, ".valid8"}, 9'(valid8), 9'(expValid));
    chk({tag, ".d8"},     9'(d8),     9'(expD8));
    chk({tag, ".cout8"},  9'(cout8),  9'(expC8));
`ifdef ARITH_OVERFLOW_EN
    chk({tag, ".v1"},     9'(v1),     9'(expV1));
    chk({tag, ".v8"},     9'(v8),     9'(expV8));
`endif
  endtask

  task automatic clearExpected();
    expD8 = '0; expD1 = '0; expC8 = 1'b0; expC1 = 1'b0;
    expV8 = 1'b0; expV1 = 1'b0; expValid = 1'b0;
  endtask

  initial begin
    logic [7:0] holdD8;
    validIn = 1'b0; aIn = '0; bIn = '0; cinIn = 1'b0; selIn = 2'b00;
    rstN = 1'b0;
    clearExpected();
    #12;
    checkOutput("reset");
    @(negedge clk);
    rstN = 1'b1;

    // 1-bit directed cases, with literal results for the 1-bit instance
    applyStimulus(1'b1, 8'h00, 8'h00, 2'b00, 1'b1); checkOutput("w1_add_cin");
    chk("w1_add_cin.lit", {7'd0, cout1, d1}, 9'b0_01);
    applyStimulus(1'b1, 8'h00, 8'h00, 2'b01, 1'b1); checkOutput("w1_sub");
    chk("w1_sub.lit", {7'd0, cout1, d1}, 9'b0_10);
    applyStimulus(1'b1, 8'h01, 8'h00, 2'b01, 1'b0); checkOutput("w1_anb");
    chk("w1_anb.lit", {7'd0, cout1, d1}, 9'b0_10);
    applyStimulus(1'b1, 8'h01, 8'h00, 2'b10, 1'b1); checkOutput("w1_inc");
    chk("w1_inc.lit", {7'd0, cout1, d1}, 9'b0_10);
    applyStimulus(1'b1, 8'h01, 8'h00, 2'b11, 1'b0); checkOutput("w1_dec");
    chk("w1_dec.lit", {7'd0, cout1, d1}, 9'b0_10);
    applyStimulus(1'b1, 8'h01, 8'h01, 2'b00, 1'b0); checkOutput("w1_add11");
    chk("w1_add11.lit", {7'd0, cout1, d1}, 9'b0_10);
    applyStimulus(1'b1, 8'h01, 8'h01, 2'b11, 1'b1); checkOutput("w1_ones_cin");
    chk("w1_ones_cin.lit", {7'd0, cout1, d1}, 9'b0_11);

    // 8-bit wrap, subtract and overflow
    applyStimulus(1'b1, 8'hFF, 8'h01, 2'b00, 1'b0); checkOutput("w8_wrap");
    chk("w8_wrap.lit", {cout8, d8}, 9'h100);
    applyStimulus(1'b1, 8'h05, 8'h07, 2'b01, 1'b1); checkOutput("w8_sub");
    chk("w8_sub.lit", {cout8, d8}, 9'h0FE);
`ifdef ARITH_OVERFLOW_EN
    chk("w8_sub.v", 9'(v8), 9'd0);
`endif
    applyStimulus(1'b1, 8'h7F, 8'h01, 2'b00, 1'b0); checkOutput("w8_ovf");
    chk("w8_ovf.d", 9'(d8), 9'h080);
`ifdef ARITH_OVERFLOW_EN
    chk("w8_ovf.v", 9'(v8), 9'd1);
`endif

    // Hold: one valid pulse then three idle cycles with changing operands
    applyStimulus(1'b1, 8'h3C, 8'h11, 2'b00, 1'b1); checkOutput("hold_load");
    holdD8 = d8;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
      checkOutput("hold_idle");
      chk("hold_idle.d8_stable", 9'(d8), 9'(holdD8));
    end

    // Randomized traffic, mostly back-to-back valid
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                    2'($urandom), 1'($urandom));
      checkOutput("rand");
    end

    // Asynchronous reset mid-cycle while a result is held and another is in flight
    applyStimulus(1'b1, 8'hA5, 8'h5A, 2'b00, 1'b1);
    checkOutput("pre_reset");
    validIn = 1'b1;
    aIn     = 8'h12;
    #2;
    rstN = 1'b0;
    #1;
    clearExpected();
    checkOutput("async_reset");
    @(posedge clk);
    #1;
    checkOutput("reset_held");
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b1, 8'h80, 8'h80, 2'b00, 1'b0); checkOutput("post_reset");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
